// File: rtl/debounce_edge_sync.sv
// Debounced, metastability-hardened level input with rise/fall pulses.
// A synchronizer chain feeds a four-state debounce FSM that flips q only after
// DEBOUNCE_CYCLES consecutive enabled samples disagree with it.
module debounce_edge_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic din,
  input  logic sample_en,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall,
  output logic busy
);

  // Smallest counter that can hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("debounce_edge_sync: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
      $error("debounce_edge_sync: DEBOUNCE_CYCLES must be 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_q[SYNC_STAGES-1];

  // The synchronizer shifts every cycle; only the debounce logic honours sample_en.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values and the block order cannot change behaviour.
  // NOTE: the sync chain is a plain shift register, not a memory, so clearing it
  // on reset is cheap and guarantees no stale '1' leaks out after reset.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sync_q <= '0;
      state  <= STABLE_LOW;
      cnt    <= '0;
      q      <= 1'b0;
      qb     <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      rise   <= 1'b0;
      fall   <= 1'b0;

      if (sample_en) begin
        unique case (state)
          STABLE_LOW: begin
            if (s) begin
              if (IMMEDIATE) begin
                state <= STABLE_HIGH;
                q     <= 1'b1;
                qb    <= 1'b0;
                rise  <= 1'b1;
              end else begin
                state <= WAIT_HIGH;
                cnt   <= CNT_W'(1);
                busy  <= 1'b1;
              end
            end
          end

          WAIT_HIGH: begin
            if (!s) begin
              // Glitch: the candidate edge did not persist, abandon it silently.
              state <= STABLE_LOW;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_HIGH;
              cnt   <= '0;
              busy  <= 1'b0;
              q     <= 1'b1;
              qb    <= 1'b0;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          STABLE_HIGH: begin
            if (!s) begin
              if (IMMEDIATE) begin
                state <= STABLE_LOW;
                q     <= 1'b0;
                qb    <= 1'b1;
                fall  <= 1'b1;
              end else begin
                state <= WAIT_LOW;
                cnt   <= CNT_W'(1);
                busy  <= 1'b1;
              end
            end
          end

          WAIT_LOW: begin
            if (s) begin
              state <= STABLE_HIGH;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              state <= STABLE_LOW;
              cnt   <= '0;
              busy  <= 1'b0;
              q     <= 1'b0;
              qb    <= 1'b1;
              fall  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          default: begin
            state <= STABLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
            q     <= 1'b0;
            qb    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debounce_edge_sync.sv
// Directed bench for debounce_edge_sync: reset, latency, glitch rejection,
// mid-count reset, strobed sampling and long sample_en gaps.
module tb_debounce_edge_sync;

  logic clk = 1'b0;
  logic sync_reset;
  logic din;
  logic sample_en;

  logic q, qb, rise, fall, busy;
  logic q1, qb1, rise1, fall1, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  debounce_edge_sync dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .din        (din),
    .sample_en  (sample_en),
    .q          (q),
    .qb         (qb),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy)
  );

  // Immediate-flip variant with a deeper synchronizer.
  debounce_edge_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk        (clk),
    .sync_reset (sync_reset),
    .din        (din),
    .sample_en  (sample_en),
    .q          (q1),
    .qb         (qb1),
    .rise       (rise1),
    .fall       (fall1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {q,qb,rise,fall,busy}=%b expected %b", tag, got, exp);
  endtask

  function automatic logic [4:0] vec(input logic qv, input logic r, input logic f, input logic b);
    return {qv, ~qv, r, f, b};
  endfunction

  function automatic logic [4:0] obs0();
    return {q, qb, rise, fall, busy};
  endfunction

  function automatic logic [4:0] obs1();
    return {q1, qb1, rise1, fall1, busy1};
  endfunction

  // One clock edge, then settle before looking at registered outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sync_reset = 1'b1;
    din        = 1'b1;
    sample_en  = 1'b1;

    // Reset wins over din=1 on both edges.
    for (int e = 0; e < 2; e++) begin
      step();
      check($sformatf("reset e%0d", e), obs0(), vec(1'b0, 1'b0, 1'b0, 1'b0));
      check($sformatf("reset1 e%0d", e), obs1(), vec(1'b0, 1'b0, 1'b0, 1'b0));
    end

    sync_reset = 1'b0;
    din        = 1'b0;
    for (int e = 0; e < 4; e++) step();
    check("idle low", obs0(), vec(1'b0, 1'b0, 1'b0, 1'b0));

    // Rising latency: busy after edges 2..8, rise/q after edge 9.
    din = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      check($sformatf("rise e%0d", e), obs0(),
            vec(e >= 9, e == 9, 1'b0, (e >= 2) && (e <= 8)));
      if (e <= 4)
        check($sformatf("rise1 e%0d", e), obs1(), vec(e >= 3, e == 3, 1'b0, 1'b0));
    end

    // Falling latency from q=1.
    din = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      step();
      check($sformatf("fall e%0d", e), obs0(),
            vec(e < 9, 1'b0, e == 9, (e >= 2) && (e <= 8)));
      if (e <= 4)
        check($sformatf("fall1 e%0d", e), obs1(), vec(e < 3, 1'b0, e == 3, 1'b0));
    end

    // Five-cycle pulse is rejected as a glitch.
    for (int e = 0; e <= 12; e++) begin
      din = (e < 5);
      step();
      check($sformatf("glitch e%0d", e), obs0(),
            vec(1'b0, 1'b0, 1'b0, (e >= 2) && (e <= 6)));
    end

    // Reset at edge 5 discards the partial count; edge 6 restarts the latency.
    din = 1'b1;
    for (int e = 0; e <= 16; e++) begin
      sync_reset = (e == 5);
      step();
      if (e < 5)
        check($sformatf("midrst e%0d", e), obs0(),
              vec(1'b0, 1'b0, 1'b0, (e >= 2) && (e <= 4)));
      else
        check($sformatf("midrst e%0d", e), obs0(),
              vec(e >= 15, e == 15, 1'b0, (e >= 8) && (e <= 14)));
    end
    sync_reset = 1'b0;

    // Back to a clean q=0 before the strobed test.
    sync_reset = 1'b1;
    din        = 1'b0;
    step();
    sync_reset = 1'b0;
    check("rst2", obs0(), vec(1'b0, 1'b0, 1'b0, 1'b0));

    // sample_en alternating: flip on the 8th enabled mismatch (edge 16).
    din = 1'b1;
    for (int e = 0; e <= 18; e++) begin
      sample_en = ((e % 2) == 0);
      step();
      check($sformatf("strobe e%0d", e), obs0(),
            vec(e >= 16, e == 16, 1'b0, (e >= 2) && (e <= 15)));
    end
    sample_en = 1'b1;

    // Partial count of 3 survives a 40-cycle sample_en gap, then 5 more enabled edges.
    din = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      step();
      check($sformatf("gap pre e%0d", e), obs0(), vec(1'b1, 1'b0, 1'b0, e >= 2));
    end
    sample_en = 1'b0;
    for (int e = 0; e < 40; e++) step();
    check("gap hold", obs0(), vec(1'b1, 1'b0, 1'b0, 1'b1));
    sample_en = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      step();
      check($sformatf("gap post e%0d", e), obs0(), vec(e < 4, 1'b0, e == 4, e < 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
